// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory: serves zero-cycle fetches like a ROM and
// is refilled from a byte stream while the CPU is held.
module imem_loadable #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int DEPTH_LOG2 = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     iaddr,
   output logic [DATA_W-1:0]     idata,
   output logic                  cpu_hold,
   input  logic                  load_start,
   input  logic                  load_end,
   input  logic [7:0]            ld_data,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   output logic                  load_done,
   output logic                  ld_err,
   output logic [DEPTH_LOG2:0]   wcount
);

   // state | meaning
   // RUN   | serving fetches, waiting for load_start
   // LOAD  | CPU held, assembling bytes into words

   localparam int BYTES  = DATA_W / 8;
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

   state_t               state, state_nxt;
   logic [BCNT_W-1:0]    bcnt;
   logic [DATA_W-1:0]    asm_word;
   logic [DATA_W-1:0]    word;
   logic [DATA_W-1:0]    mem [DEPTH];
   logic                 accept;
   logic                 last_byte;
   logic                 mem_full;

   assign accept    = ld_valid && ld_ready;
   assign last_byte = (bcnt == BCNT_W'(BYTES - 1));
   assign mem_full  = (wcount == (DEPTH_LOG2 + 1)'(DEPTH - 1));

   // Incoming byte merged into its little-endian lane; complete on the last byte.
   always_comb begin
      word = asm_word;
      word[bcnt*8 +: 8] = ld_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:  if (load_start) state_nxt = LOAD;
         LOAD: begin
            if (load_end)                               state_nxt = RUN;
            else if (accept && last_byte && mem_full)   state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      cpu_hold = (state == LOAD);
      ld_ready = (state == LOAD) && !load_end;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bcnt      <= '0;
         asm_word  <= '0;
         wcount    <= '0;
         load_done <= 1'b0;
         ld_err    <= 1'b0;
      end else begin
         load_done <= 1'b0;
         if (state == RUN) begin
            if (load_start) begin
               bcnt   <= '0;
               wcount <= '0;
               ld_err <= 1'b0;
            end
         end else if (load_end) begin
            // A partial word is dropped; only a clean word boundary counts as done.
            if (bcnt == '0) load_done <= 1'b1;
            else            ld_err    <= 1'b1;
            bcnt <= '0;
         end else if (accept) begin
            if (last_byte) begin
               bcnt   <= '0;
               wcount <= wcount + (DEPTH_LOG2 + 1)'(1);
               if (mem_full) load_done <= 1'b1;
            end else begin
               asm_word <= word;
               bcnt     <= bcnt + BCNT_W'(1);
            end
         end
      end
   end

   // Contents deliberately survive reset so an aborted load keeps finished words.
   always_ff @(posedge clock) begin
      if (accept && last_byte) mem[wcount[DEPTH_LOG2-1:0]] <= word;
   end

   always_comb begin
      idata = '0;
      if (state == RUN && (iaddr >> (DEPTH_LOG2 + 1)) == '0)
         idata = mem[iaddr[DEPTH_LOG2:1]];
   end

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: vector table, directed corner sequences and random
// traffic checked against a queue-based reference model.
module tb_imem_loadable;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] iaddr = '0;
   logic [15:0] idata;
   logic        cpu_hold;
   logic        load_start = 1'b0;
   logic        load_end = 1'b0;
   logic [7:0]  ld_data = '0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic        load_done;
   logic        ld_err;
   logic [5:0]  wcount;

   imem_loadable #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(5)) dut (
      .clock(clock), .reset(reset), .iaddr(iaddr), .idata(idata),
      .cpu_hold(cpu_hold), .load_start(load_start), .load_end(load_end),
      .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .load_done(load_done), .ld_err(ld_err), .wcount(wcount)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // reference model: loading flag, queue of pending bytes, word image
   bit          m_load, m_done, m_err;
   int          m_wc;
   logic [7:0]  q[$];
   logic [15:0] mm[32];
   bit          kn[32];

   typedef struct {
      bit          st, en, v;
      logic [7:0]  d;
      logic [15:0] a;
      bit          hold, rdy, done, err;
      logic [5:0]  wc;
      logic [15:0] dat;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_load = 0; m_done = 0; m_err = 0; m_wc = 0;
      q.delete();
   endtask

   task automatic model_edge();
      m_done = 0;
      if (!m_load) begin
         if (load_start) begin
            m_load = 1; m_wc = 0; m_err = 0;
            q.delete();
         end
      end else if (load_end) begin
         if (q.size() == 0) m_done = 1;
         else               m_err = 1;
         q.delete();
         m_load = 0;
      end else if (ld_valid) begin
         q.push_back(ld_data);
         if (q.size() == 2) begin
            mm[m_wc] = {q[1], q[0]};
            kn[m_wc] = 1;
            m_wc++;
            q.delete();
            if (m_wc == 32) begin
               m_load = 0;
               m_done = 1;
            end
         end
      end
   endtask

   task automatic compare_model(string tag);
      int idx;
      chk({tag, "_hold"},  cpu_hold,  m_load);
      chk({tag, "_ready"}, ld_ready,  m_load && !load_end);
      chk({tag, "_done"},  load_done, m_done);
      chk({tag, "_err"},   ld_err,    m_err);
      chk({tag, "_wc"},    wcount,    m_wc);
      idx = iaddr / 2;
      if (m_load || iaddr >= 16'h0040) chk({tag, "_idata0"}, idata, 16'h0000);
      else if (kn[idx])                chk({tag, "_idata"},  idata, mm[idx]);
   endtask

   task automatic tick(string tag);
      model_edge();
      @(posedge clock);
      #1;
      load_start = 0; load_end = 0; ld_valid = 0;
      #1;
      compare_model(tag);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) kn[i] = 0;
      model_reset();

      // reset held from time zero
      repeat (2) @(posedge clock);
      #2;
      chk("rst_hold", cpu_hold, 0);
      chk("rst_ready", ld_ready, 0);
      chk("rst_done", load_done, 0);
      chk("rst_err", ld_err, 0);
      chk("rst_wc", wcount, 0);
      reset = 0;

      // st en v data addr | hold rdy done err wc idata
      tbl[0]  = '{1,0,0,8'h00,16'h0000, 1,1,0,0,6'd0,16'h0000};
      tbl[1]  = '{0,0,1,8'h03,16'h0000, 1,1,0,0,6'd0,16'h0000};
      tbl[2]  = '{0,0,1,8'h61,16'h0000, 1,1,0,0,6'd1,16'h0000};
      tbl[3]  = '{0,0,1,8'hBE,16'h0002, 1,1,0,0,6'd1,16'h0000};
      tbl[4]  = '{0,0,1,8'hEF,16'h0002, 1,1,0,0,6'd2,16'h0000};
      tbl[5]  = '{0,1,0,8'h00,16'h0000, 0,0,1,0,6'd2,16'h6103};
      tbl[6]  = '{0,0,0,8'h00,16'h0001, 0,0,0,0,6'd2,16'h6103};
      tbl[7]  = '{0,0,0,8'h00,16'h0002, 0,0,0,0,6'd2,16'hEFBE};
      tbl[8]  = '{1,0,0,8'h00,16'h0000, 1,1,0,0,6'd0,16'h0000};
      tbl[9]  = '{0,0,1,8'h11,16'h0000, 1,1,0,0,6'd0,16'h0000};
      tbl[10] = '{0,0,1,8'h22,16'h0000, 1,1,0,0,6'd1,16'h0000};
      tbl[11] = '{0,0,1,8'hAA,16'h0000, 1,1,0,0,6'd1,16'h0000};
      tbl[12] = '{0,1,1,8'h55,16'h0002, 0,0,0,1,6'd1,16'hEFBE};
      tbl[13] = '{0,0,0,8'h00,16'h0000, 0,0,0,1,6'd1,16'h2211};
      tbl[14] = '{0,0,0,8'h00,16'h0003, 0,0,0,1,6'd1,16'hEFBE};
      tbl[15] = '{0,1,0,8'h00,16'h0000, 0,0,0,1,6'd1,16'h2211};

      for (int i = 0; i < 16; i++) begin
         load_start = tbl[i].st; load_end = tbl[i].en;
         ld_valid = tbl[i].v; ld_data = tbl[i].d; iaddr = tbl[i].a;
         #1;
         if (tbl[i].en) chk($sformatf("vec%0d_end_ready", i), ld_ready, 0);
         tick($sformatf("vec%0d_model", i));
         chk($sformatf("vec%0d_hold", i),  cpu_hold,  tbl[i].hold);
         chk($sformatf("vec%0d_ready", i), ld_ready,  tbl[i].rdy);
         chk($sformatf("vec%0d_done", i),  load_done, tbl[i].done);
         chk($sformatf("vec%0d_err", i),   ld_err,    tbl[i].err);
         chk($sformatf("vec%0d_wc", i),    wcount,    tbl[i].wc);
         chk($sformatf("vec%0d_idata", i), idata,     tbl[i].dat);
      end

      // full-depth load ends itself on the 64th byte
      load_start = 1;
      tick("full_start");
      for (int b = 0; b < 64; b++) begin
         ld_valid = 1; ld_data = 8'($urandom); iaddr = 16'($urandom);
         tick($sformatf("full_b%0d", b));
      end
      chk("full_done", load_done, 1);
      chk("full_wc", wcount, 32);
      chk("full_hold", cpu_hold, 0);
      ld_valid = 1; ld_data = 8'h77;
      #1;
      chk("full_65th_ready", ld_ready, 0);
      tick("full_after");
      chk("full_done_1cyc", load_done, 0);
      iaddr = 16'h0040; #1;
      chk("range_40", idata, 16'h0000);
      iaddr = 16'h003E; #1;
      chk("range_3e", idata, mm[31]);
      for (int w = 0; w < 32; w++) begin
         iaddr = 16'(w * 2);
         tick($sformatf("full_rd%0d", w));
      end

      // reset mid-load after three words and a stray byte
      load_start = 1;
      tick("rml_start");
      for (int b = 1; b <= 7; b++) begin
         ld_valid = 1; ld_data = 8'(b);
         tick($sformatf("rml_b%0d", b));
      end
      chk("rml_wc3", wcount, 3);
      #1 reset = 1;
      model_reset();
      #1;
      chk("rml_hold", cpu_hold, 0);
      chk("rml_ready", ld_ready, 0);
      chk("rml_wc", wcount, 0);
      chk("rml_err", ld_err, 0);
      #1 reset = 0;
      iaddr = 16'h0000; #1; chk("rml_w0", idata, 16'h0201);
      iaddr = 16'h0002; #1; chk("rml_w1", idata, 16'h0403);
      iaddr = 16'h0004; #1; chk("rml_w2", idata, 16'h0605);
      iaddr = 16'h0006; #1; chk("rml_w3_old", idata, mm[3]);

      // random traffic against the model
      for (int c = 0; c < 600; c++) begin
         load_start = ($urandom_range(0, 19) == 0);
         load_end   = ($urandom_range(0, 29) == 0);
         ld_valid   = ($urandom_range(0, 3) != 0);
         ld_data    = 8'($urandom);
         iaddr      = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
         #1;
         chk("rnd_pre_ready", ld_ready, m_load && !load_end);
         tick($sformatf("rnd%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, run-time loadable instruction memory for the 16-bit pipelined MIPS core. It replaces the fixed, hard-coded program ROM with a RAM image that an external byte source can fill without resynthesising. The byte source is a UART receiver or a debug bridge. While a load is in progress the block holds the CPU; afterwards it serves instruction fetches exactly like the ROM it replaces.

## Interface
Parameters:
- `DATA_W`, default 16: instruction width. Must be a multiple of 8. BYTES = DATA_W/8.
- `ADDR_W`, default 16: width of the CPU fetch address (byte address).
- `DEPTH_LOG2`, default 5: log2 of the number of instruction words (default 32 words).

Ports:
- `clock`, in, 1: single clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `iaddr`, in, ADDR_W: CPU fetch byte address. Word index = `iaddr[DEPTH_LOG2:1]`; bit 0 is ignored.
- `idata`, out, DATA_W: instruction word, combinational read.
- `cpu_hold`, out, 1: high while loading. The CPU must stall its PC.
- `load_start`, in, 1: one-cycle request to begin a load.
- `load_end`, in, 1: early termination of a load.
- `ld_data`, in, 8: incoming program byte.
- `ld_valid`, in, 1: `ld_data` valid.
- `ld_ready`, out, 1: the byte is accepted on an edge where `ld_valid` and `ld_ready` are both high.
- `load_done`, out, 1: one-cycle pulse when a load finishes without error.
- `ld_err`, out, 1: sticky flag for a partial word at termination.
- `wcount`, out, DEPTH_LOG2+1: number of words written by the current or last load.

## Operation
FSM states: RUN, LOAD.

RUN:
- `load_start` moves the FSM to LOAD.
- On that transition: `wcount`←0, `ld_err`←0, byte counter `bcnt`←0.
- All other load inputs are ignored.

LOAD:
- Bytes assemble little-endian. The k-th byte of a word fills bits [8k+7:8k].
- An accepted byte with `bcnt` < BYTES-1 stores into the assembly register and increments `bcnt`.
- An accepted byte with `bcnt` = BYTES-1 writes {byte, assembled bytes} to `mem[wcount]`, increments `wcount` and clears `bcnt`.
- Write that makes `wcount` = 2^DEPTH_LOG2: FSM returns to RUN and `load_done` pulses. Further bytes are refused.
- `load_end` with `bcnt` = 0: FSM returns to RUN and `load_done` pulses.
- `load_end` with `bcnt` ≠ 0: the partial word is discarded (memory untouched), `ld_err`←1, FSM returns to RUN, no `load_done`.
- `load_start` while in LOAD is ignored.

`ld_ready` = (state = LOAD) && !`load_end`. When `load_end` and `ld_valid` are both high, termination wins and the byte is not accepted.

`cpu_hold` = (state = LOAD).

`idata` rules:
- 0 if state = LOAD, so a NOP is presented while the CPU is held.
- 0 if `iaddr[ADDR_W-1:DEPTH_LOG2+1]` ≠ 0 (out-of-range fetch).
- Otherwise `mem[iaddr[DEPTH_LOG2:1]]`.

Memory contents are not cleared by reset or by `load_start`. Words not rewritten keep their previous values. Initial contents are undefined; the bench must load before fetching.

Asynchronous reset values:
- state RUN, `cpu_hold` 0, `ld_ready` 0, `load_done` 0, `ld_err` 0, `wcount` 0, `bcnt` 0.
- Reset during LOAD aborts the load immediately. Words already written remain readable.

## Timing
- `idata` is combinational from `iaddr` and memory (zero-cycle fetch, same as the prior ROM).
- A memory write occurs on the edge that accepts the last byte of a word. The new value is visible on `idata` after that edge.
- `load_start` is sampled at edge N. `cpu_hold` and `ld_ready` go high after edge N. The first byte can be accepted at edge N+1.
- Byte throughput: one byte per cycle at most.
- `load_done` is registered. It is high for exactly the one cycle following the terminating edge. `cpu_hold` falls on that same edge.
- `ld_err` is set on the terminating edge and stays high until the next accepted `load_start` or reset.

## Test plan
With DATA_W=16, DEPTH_LOG2=5, ADDR_W=16:
1. Reset check: assert `reset` asynchronously mid-cycle → immediately `cpu_hold`=0, `ld_ready`=0, `load_done`=0, `ld_err`=0, `wcount`=0.
2. Single-word load: `load_start`, bytes 0x03 then 0x61, then `load_end` → `load_done` pulses for one cycle, `wcount`=1, `iaddr`=0x0000 gives `idata`=0x6103, `iaddr`=0x0001 also gives 0x6103.
3. Full-depth load: 64 bytes with `ld_valid` held high → `mem[31]` written on the 64th byte, auto return to RUN, `load_done` pulse, `wcount`=32; a 65th byte sees `ld_ready`=0.
4. Odd-byte termination: after one complete word plus one extra byte (0xAA), assert `load_end` together with `ld_valid` → byte not accepted, `ld_err`=1, no `load_done`, `wcount`=1, `mem[1]` unchanged.
5. Reset mid-load: after 3 words are written, assert `reset` → state RUN, `wcount`=0, words 0–2 readable with their loaded values.
6. Hold and range: during LOAD, any `iaddr` gives `idata`=0; in RUN, `iaddr`=0x0040 gives `idata`=0 and `iaddr`=0x003E gives `mem[31]`.
